// File: rtl/eth_sw_pkg.sv
// Shared switch definitions: datapath width, arbiter states, port identifiers
// and the default per-packet word limit.
package eth_sw_pkg;

    localparam int DATA_W        = 32;
    localparam int MAX_WORDS_DEF = 375;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

endpackage

// File: rtl/eth_rr_arb2.sv
// Two-requester round-robin pick: a lone requester always wins, a tie goes to
// the port that did not win last time.
module eth_rr_arb2
    import eth_sw_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_e   lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (lastGrant == PORT_A) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/eth_port_arb.sv
// Shares one output port between ports A and B, granting whole packets
// round-robin, with backpressure, framing-error detection and packet counters.
//
// state   | meaning
// IDLE    | output free; arbitrate among SOP requests, drop stray non-SOP words
// GRANT_A | port A owns the output until EOP or word limit; B is held off
// GRANT_B | port B owns the output until EOP or word limit; A is held off
module eth_port_arb
    import eth_sw_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inDataA,
    input  logic              inValidA,
    input  logic              inSopA,
    input  logic              inEopA,
    input  logic [DATA_W-1:0] inDataB,
    input  logic              inValidB,
    input  logic              inSopB,
    input  logic              inEopB,
    output logic              portAStall,
    output logic              portBStall,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    output logic              outSop,
    output logic              outEop,
    output logic              outSrc,
    output logic              errFrame,
    output logic [15:0]       pktCntA,
    output logic [15:0]       pktCntB
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    arb_state_e        state;
    port_id_e          last_grant;
    port_id_e          src;
    logic [CNT_W-1:0]  words_left;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              cur_valid;
    logic              cur_sop;
    logic              cur_eop;
    logic [DATA_W-1:0] cur_data;
    logic              fwd;
    logic              at_limit;
    logic              end_ok;
    logic              end_trunc;
    logic              err;

    assign req = {inValidB & inSopB, inValidA & inSopA};

    eth_rr_arb2 u_rr (
        .req       (req),
        .lastGrant (last_grant),
        .grant     (grant)
    );

    // In IDLE the arbiter winner is the source; otherwise the packet owner.
    assign src       = (state == IDLE) ? port_id_e'(grant[1])
                                       : ((state == GRANT_B) ? PORT_B : PORT_A);
    assign cur_valid = (src == PORT_B) ? inValidB : inValidA;
    assign cur_sop   = (src == PORT_B) ? inSopB   : inSopA;
    assign cur_eop   = (src == PORT_B) ? inEopB   : inEopA;
    assign cur_data  = (src == PORT_B) ? inDataB  : inDataA;

    // words_left counts down the words still allowed after the current one.
    assign fwd       = (state == IDLE) ? (grant != 2'b00) : (cur_valid & ~cur_sop);
    assign at_limit  = (state == IDLE) ? (MAX_WORDS == 1) : (words_left == CNT_W'(1));
    assign end_ok    = fwd & cur_eop;
    assign end_trunc = fwd & ~cur_eop & at_limit;
    assign err       = end_trunc
                     | ((state == IDLE) ? ((inValidA & ~inSopA) | (inValidB & ~inSopB))
                                        : (cur_valid & cur_sop));

    always_comb begin
        portAStall = 1'b0;
        portBStall = 1'b0;
        if (reset) begin
            portAStall = 1'b1;
            portBStall = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    portAStall = req[0] & ~grant[0];
                    portBStall = req[1] & ~grant[1];
                end
                GRANT_A: portBStall = 1'b1;
                GRANT_B: portAStall = 1'b1;
                default: begin
                    portAStall = 1'b1;
                    portBStall = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_B;
            words_left <= '0;
            outData    <= '0;
            outValid   <= 1'b0;
            outSop     <= 1'b0;
            outEop     <= 1'b0;
            outSrc     <= 1'b0;
            errFrame   <= 1'b0;
            pktCntA    <= '0;
            pktCntB    <= '0;
        end else begin
            outValid <= fwd;
            outSop   <= fwd & (state == IDLE);
            outEop   <= end_ok | end_trunc;
            errFrame <= err;
            if (fwd) begin
                outData <= cur_data;
                outSrc  <= src;
            end

            if (end_ok | end_trunc) begin
                state      <= IDLE;
                last_grant <= src;
            end else if (fwd && state == IDLE) begin
                state      <= (src == PORT_B) ? GRANT_B : GRANT_A;
                words_left <= CNT_W'(MAX_WORDS - 1);
            end else if (fwd) begin
                words_left <= words_left - 1'b1;
            end else if (state != IDLE && state != GRANT_A && state != GRANT_B) begin
                state <= IDLE;
            end

            // Truncated packets are not counted.
            if (end_ok) begin
                if (src == PORT_B) pktCntB <= pktCntB + 16'd1;
                else               pktCntA <= pktCntA + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_port_arb.sv
// Self-checking bench for eth_port_arb: directed scenarios plus a randomized
// two-port run compared against a packet-level behavioural model.
module tb_eth_port_arb;
    import eth_sw_pkg::*;

    localparam int MW = 8;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic [DATA_W-1:0] inDataA  = '0;
    logic              inValidA = 1'b0;
    logic              inSopA   = 1'b0;
    logic              inEopA   = 1'b0;
    logic [DATA_W-1:0] inDataB  = '0;
    logic              inValidB = 1'b0;
    logic              inSopB   = 1'b0;
    logic              inEopB   = 1'b0;
    logic              portAStall, portBStall;
    logic [DATA_W-1:0] outData;
    logic              outValid, outSop, outEop, outSrc, errFrame;
    logic [15:0]       pktCntA, pktCntB;

    int checks = 0;
    int errors = 0;

    // reference model state: owner -1 = nobody, ports 0=A 1=B
    int m_owner, m_last, m_nw;
    int m_cnt [2];
    logic [33:0] qa[$];
    logic [33:0] qb[$];

    always #5 clk = ~clk;

    eth_port_arb #(.MAX_WORDS(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .inDataA    (inDataA),
        .inValidA   (inValidA),
        .inSopA     (inSopA),
        .inEopA     (inEopA),
        .inDataB    (inDataB),
        .inValidB   (inValidB),
        .inSopB     (inSopB),
        .inEopB     (inEopB),
        .portAStall (portAStall),
        .portBStall (portBStall),
        .outData    (outData),
        .outValid   (outValid),
        .outSop     (outSop),
        .outEop     (outEop),
        .outSrc     (outSrc),
        .errFrame   (errFrame),
        .pktCntA    (pktCntA),
        .pktCntB    (pktCntB)
    );

    function automatic logic [36:0] obs();
        return {outValid, outSop, outEop, outSrc, errFrame, outData};
    endfunction

    function automatic logic [36:0] wexp(input logic v, input logic s, input logic e,
                                         input logic src, input logic er,
                                         input logic [31:0] d);
        return {v, s, e, src, er, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic s, input logic e, input logic [31:0] d);
        inValidA = v; inSopA = s; inEopA = e; inDataA = d;
    endtask

    task automatic drive_b(input logic v, input logic s, input logic e, input logic [31:0] d);
        inValidB = v; inSopB = s; inEopB = e; inDataB = d;
    endtask

    task automatic idle_inputs();
        drive_a(1'b0, 1'b0, 1'b0, '0);
        drive_b(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        drive_a(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (obs() !== 37'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", obs(), 37'd0);
        end
        checks++;
        if ({portAStall, portBStall} !== 2'b11) begin
            errors++; $display("FAIL reset_stalls: got %b want 11", {portAStall, portBStall});
        end
        checks++;
        if ({pktCntA, pktCntB} !== 32'd0) begin
            errors++; $display("FAIL reset_counts: got %h want 0", {pktCntA, pktCntB});
        end
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({portAStall, portBStall} !== 2'b00) begin
            errors++; $display("FAIL idle_stalls: got %b want 00", {portAStall, portBStall});
        end
        tick();
        checks++;
        if ({outValid, errFrame} !== 2'b00) begin
            errors++; $display("FAIL idle_output: got %b want 00", {outValid, errFrame});
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, i == 0, i == 3, 32'(32'h11 + i));
            #1;
            checks++;
            if (portAStall !== 1'b0) begin
                errors++; $display("FAIL single_pkt stall word %0d: got %b want 0", i, portAStall);
            end
            tick();
            checks++;
            if (obs() !== wexp(1'b1, i == 0, i == 3, 1'b0, 1'b0, 32'(32'h11 + i))) begin
                errors++;
                $display("FAIL single_pkt word %0d: got %h want %h", i, obs(),
                         wexp(1'b1, i == 0, i == 3, 1'b0, 1'b0, 32'(32'h11 + i)));
            end
        end
        idle_inputs();
        tick();
        checks++;
        if ({outValid, pktCntA, pktCntB} !== {1'b0, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL single_pkt end: got %h want %h", {outValid, pktCntA, pktCntB},
                     {1'b0, 16'd1, 16'd0});
        end
    endtask

    task automatic test_contention();
        logic [34:0] sa [7];
        logic [34:0] sb [7];
        logic [1:0]  st [7];
        logic [36:0] ex [7];
        sa = '{{3'b110, 32'hA1}, {3'b101, 32'hA2}, {3'b000, 32'h0}, {3'b000, 32'h0},
               {3'b111, 32'hA3}, {3'b111, 32'hA4}, {3'b111, 32'hA4}};
        sb = '{{3'b110, 32'hB1}, {3'b110, 32'hB1}, {3'b110, 32'hB1}, {3'b101, 32'hB2},
               {3'b111, 32'hB3}, {3'b111, 32'hB3}, {3'b000, 32'h0}};
        st = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
        ex = '{{5'b11000, 32'hA1}, {5'b10100, 32'hA2}, {5'b11010, 32'hB1},
               {5'b10110, 32'hB2}, {5'b11100, 32'hA3}, {5'b11110, 32'hB3},
               {5'b11100, 32'hA4}};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive_a(sa[c][34], sa[c][33], sa[c][32], sa[c][31:0]);
            drive_b(sb[c][34], sb[c][33], sb[c][32], sb[c][31:0]);
            #1;
            checks++;
            if ({portAStall, portBStall} !== st[c]) begin
                errors++;
                $display("FAIL contention stall cycle %0d: got %b want %b", c,
                         {portAStall, portBStall}, st[c]);
            end
            tick();
            checks++;
            if (obs() !== ex[c]) begin
                errors++; $display("FAIL contention out cycle %0d: got %h want %h", c, obs(), ex[c]);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if ({pktCntA, pktCntB} !== {16'd3, 16'd2}) begin
            errors++;
            $display("FAIL contention counts: got %h want %h", {pktCntA, pktCntB}, {16'd3, 16'd2});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 1'b1, 1'b1, 32'(32'h30 + k));
            #1;
            checks++;
            if (portAStall !== 1'b0) begin
                errors++; $display("FAIL b2b stall pkt %0d: got %b want 0", k, portAStall);
            end
            tick();
            checks++;
            if (obs() !== wexp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'(32'h30 + k))) begin
                errors++;
                $display("FAIL b2b pkt %0d: got %h want %h", k, obs(),
                         wexp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'(32'h30 + k)));
            end
            idle_inputs();
            tick();
            checks++;
            if ({outValid, errFrame} !== 2'b00) begin
                errors++; $display("FAIL b2b gap %0d: got %b want 00", k, {outValid, errFrame});
            end
        end
        checks++;
        if (pktCntA !== 16'd3) begin
            errors++; $display("FAIL b2b count: got %0d want 3", pktCntA);
        end
    endtask

    task automatic test_max_words();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, i == 0, 1'b0, 32'(32'h40 + i));
            #1;
            checks++;
            if (portAStall !== 1'b0) begin
                errors++; $display("FAIL maxw stall word %0d: got %b want 0", i, portAStall);
            end
            tick();
            checks++;
            if (i < MW) begin
                if (obs() !== wexp(1'b1, i == 0, i == MW - 1, 1'b0, i == MW - 1, 32'(32'h40 + i))) begin
                    errors++;
                    $display("FAIL maxw word %0d: got %h want %h", i, obs(),
                             wexp(1'b1, i == 0, i == MW - 1, 1'b0, i == MW - 1, 32'(32'h40 + i)));
                end
            end else if ({outValid, errFrame} !== 2'b01) begin
                errors++; $display("FAIL maxw drop word %0d: got %b want 01", i, {outValid, errFrame});
            end
        end
        idle_inputs();
        tick();
        checks++;
        if ({errFrame, pktCntA} !== 17'd0) begin
            errors++; $display("FAIL maxw end: got %h want 0", {errFrame, pktCntA});
        end
    endtask

    task automatic test_no_sop();
        do_reset();
        drive_b(1'b1, 1'b0, 1'b0, 32'h55);
        #1;
        checks++;
        if (portBStall !== 1'b0) begin
            errors++; $display("FAIL nosop stall: got %b want 0", portBStall);
        end
        tick();
        checks++;
        if ({outValid, errFrame} !== 2'b01) begin
            errors++; $display("FAIL nosop drop: got %b want 01", {outValid, errFrame});
        end
        idle_inputs();
        tick();
        checks++;
        if ({outValid, errFrame, pktCntB} !== 18'd0) begin
            errors++; $display("FAIL nosop after: got %h want 0", {outValid, errFrame, pktCntB});
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive_a(1'b1, 1'b1, 1'b0, 32'h61);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 32'h62);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 32'h63);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 37'd0) begin
            errors++; $display("FAIL midrst outputs: got %h want 0", obs());
        end
        checks++;
        if ({portAStall, portBStall} !== 2'b11) begin
            errors++; $display("FAIL midrst stalls: got %b want 11", {portAStall, portBStall});
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if ({outValid, outEop} !== 2'b00) begin
            errors++; $display("FAIL midrst no_eop: got %b want 00", {outValid, outEop});
        end
        for (int i = 0; i < 2; i++) begin
            drive_b(1'b1, i == 0, i == 1, 32'(32'h71 + i));
            tick();
            checks++;
            if (obs() !== wexp(1'b1, i == 0, i == 1, 1'b1, 1'b0, 32'(32'h71 + i))) begin
                errors++;
                $display("FAIL midrst B word %0d: got %h want %h", i, obs(),
                         wexp(1'b1, i == 0, i == 1, 1'b1, 1'b0, 32'(32'h71 + i)));
            end
        end
        idle_inputs();
        tick();
        checks++;
        if ({pktCntA, pktCntB} !== {16'd0, 16'd1}) begin
            errors++; $display("FAIL midrst counts: got %h want %h", {pktCntA, pktCntB}, {16'd0, 16'd1});
        end
    endtask

    function automatic void push_word(input int p, input logic [33:0] w);
        if (p == 0) qa.push_back(w);
        else        qb.push_back(w);
    endfunction

    // Packets of 1..10 words (longer than MW get truncated), with occasional
    // stray non-SOP words between packets and stray SOP words inside them.
    function automatic void gen_pkt(input int p);
        int len;
        if ($urandom_range(0, 19) == 0)
            push_word(p, {1'b0, 1'($urandom_range(0, 1)), $urandom()});
        len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++) begin
            if (i > 0 && $urandom_range(0, 29) == 0)
                push_word(p, {1'b1, 1'b0, $urandom()});
            push_word(p, {i == 0, i == len - 1, $urandom()});
        end
    endfunction

    task automatic test_random(input int ncyc);
        logic        v [2];
        logic        s [2];
        logic        e [2];
        logic [31:0] d [2];
        logic        hold [2];
        logic        xs [2];
        logic [33:0] hd;
        logic        ev, es, ee, esrc, eerr;
        logic [31:0] ed;
        int          w, o;
        do_reset();
        m_owner = -1; m_last = 1; m_nw = 0; m_cnt = '{0, 0};
        qa.delete(); qb.delete();
        hold = '{1'b0, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            if (qa.size() < 4) gen_pkt(0);
            if (qb.size() < 4) gen_pkt(1);
            for (int p = 0; p < 2; p++) begin
                hd   = (p == 0) ? qa[0] : qb[0];
                v[p] = hold[p] || ($urandom_range(0, 3) != 0);
                s[p] = v[p] & hd[33];
                e[p] = v[p] & hd[32];
                d[p] = v[p] ? hd[31:0] : 32'd0;
            end

            ev = 1'b0; es = 1'b0; ee = 1'b0; esrc = 1'b0; eerr = 1'b0; ed = '0;
            xs = '{1'b0, 1'b0};
            if (m_owner < 0) begin
                w = -1;
                if (v[0] && s[0] && v[1] && s[1]) w = 1 - m_last;
                else if (v[0] && s[0])            w = 0;
                else if (v[1] && s[1])            w = 1;
                for (int p = 0; p < 2; p++) xs[p] = v[p] && s[p] && (w != p);
                eerr = (v[0] && !s[0]) || (v[1] && !s[1]);
                if (w >= 0) begin
                    ev = 1'b1; es = 1'b1; esrc = w[0]; ed = d[w];
                    m_nw = 1; m_owner = w;
                end
            end else begin
                o = m_owner;
                xs[1 - o] = 1'b1;
                if (v[o] && s[o]) eerr = 1'b1;
                else if (v[o]) begin
                    ev = 1'b1; esrc = o[0]; ed = d[o]; m_nw++;
                end
            end
            if (ev) begin
                w = int'(esrc);
                if (e[w]) begin
                    ee = 1'b1; m_cnt[w]++; m_last = w; m_owner = -1;
                end else if (m_nw == MW) begin
                    ee = 1'b1; eerr = 1'b1; m_last = w; m_owner = -1;
                end
            end

            drive_a(v[0], s[0], e[0], d[0]);
            drive_b(v[1], s[1], e[1], d[1]);
            #1;
            checks++;
            if ({portAStall, portBStall} !== {xs[0], xs[1]}) begin
                errors++;
                $display("FAIL rand stall cycle %0d: got %b want %b", c,
                         {portAStall, portBStall}, {xs[0], xs[1]});
            end
            tick();
            checks++;
            if (ev) begin
                if (obs() !== {ev, es, ee, esrc, eerr, ed}) begin
                    errors++;
                    $display("FAIL rand out cycle %0d: got %h want %h", c, obs(),
                             {ev, es, ee, esrc, eerr, ed});
                end
            end else if ({outValid, errFrame} !== {1'b0, eerr}) begin
                errors++;
                $display("FAIL rand noout cycle %0d: got %b want %b", c, {outValid, errFrame},
                         {1'b0, eerr});
            end
            checks++;
            if ({pktCntA, pktCntB} !== {16'(m_cnt[0]), 16'(m_cnt[1])}) begin
                errors++;
                $display("FAIL rand counts cycle %0d: got %h want %h", c, {pktCntA, pktCntB},
                         {16'(m_cnt[0]), 16'(m_cnt[1])});
            end

            for (int p = 0; p < 2; p++) begin
                if (v[p] && !xs[p]) begin
                    if (p == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                    hold[p] = 1'b0;
                end else begin
                    hold[p] = v[p];
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_contention();
        test_back_to_back();
        test_max_words();
        test_no_sop();
        test_reset_mid_packet();
        test_random(2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/eth_port_arb.md
ETH_PORT_ARB -- requirements
Module: eth_port_arb

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 375, meaning maximum words per packet before forced termination.
REQ-002 The block SHALL have these ports:
  clk  input  1  sole clock, rising edge
  reset  input  1  asynchronous, active-high reset
  inDataA  input  32  port A packet word
  inValidA  input  1  port A word present
  inSopA  input  1  port A first word of packet
  inEopA  input  1  port A last word of packet
  inDataB, inValidB, inSopB, inEopB  input  32/1/1/1  port B equivalents
  portAStall  output  1  port A word not accepted this cycle; source holds it
  portBStall  output  1  port B equivalent
  outData  output  32  forwarded word
  outValid  output  1  outData carries a word
  outSop  output  1  first word of forwarded packet
  outEop  output  1  last word of forwarded packet
  outSrc  output  1  source of forwarded word, 0=A, 1=B
  errFrame  output  1  one-cycle framing-error pulse
  pktCntA  output  16  packets forwarded from A
  pktCntB  output  16  packets forwarded from B

Function
REQ-003 Purpose: share one switch output port between ports A and B with packet-level round-robin arbitration and backpressure.
REQ-004 States: IDLE, GRANT_A, GRANT_B.
REQ-005 A port requests when inValid=1 and inSop=1 in IDLE.
REQ-006 IDLE, one requester: go to that port's GRANT state; its SOP word is accepted in the same cycle.
REQ-007 IDLE, both requesting: grant the port not granted last (lastGrant register, reset value B so A wins first); loser's stall=1.
REQ-008 In GRANT_x, the granted port's stall SHALL be 0 and the other port's stall SHALL be 1.
REQ-009 In IDLE, a port's stall SHALL be 0 unless it loses arbitration that cycle.
REQ-010 Accepted word (valid=1, stall=0) SHALL appear on outData/outSop/outEop/outSrc with outValid=1 exactly one cycle later (registered output).
REQ-011 Granted port with inValid=0: no word forwarded (outValid=0 next cycle), state held.
REQ-012 Accepted word with inEop=1: return to IDLE next cycle, update lastGrant, increment that port's pktCnt.
REQ-013 Single-word packet (inSop=inEop=1): granted, forwarded with outSop=outEop=1, return to IDLE; one IDLE cycle always separates packets.
REQ-014 Word count per packet SHALL be tracked; on the MAX_WORDS-th accepted word without inEop, forward it with outEop forced 1, pulse errFrame, return to IDLE, no pktCnt increment.
REQ-015 In IDLE, a valid word with inSop=0 SHALL be accepted (stall=0), dropped (no output), and pulse errFrame.
REQ-016 In GRANT_x, a granted word with inSop=1 SHALL be dropped and pulse errFrame; state and word count unchanged.
REQ-017 errFrame SHALL be registered, aligned with the cycle the corresponding output would appear; simultaneous errors produce a single pulse.
REQ-018 pktCntA/pktCntB SHALL wrap 16'hFFFF -> 0.

Reset
REQ-019 reset asserted SHALL immediately force: state IDLE, lastGrant=B, word count 0, outData=0, outValid=0, outSop=0, outEop=0, outSrc=0, errFrame=0, pktCntA=0, pktCntB=0.
REQ-020 During reset portAStall and portBStall SHALL be 1.
REQ-021 Reset mid-packet SHALL abandon the packet with no outEop emitted; after release, arbitration restarts from IDLE.

Structure
REQ-022 Shared package eth_sw_pkg SHALL hold DATA_W=32, the arbiter state enum, port-id enum (PORT_A=0, PORT_B=1), and MAX_WORDS default.
REQ-023 Two-requester round-robin decision SHALL be a sub-module eth_rr_arb2 (req[1:0], lastGrant in, grant one-hot out, combinational).

Verification
REQ-024 A sends 4-word packet 0x11..0x14, B idle -> outSrc=0, 4 words one cycle delayed, outSop on 0x11, outEop on 0x14, pktCntA=1.
REQ-025 A and B assert SOP same cycle after reset -> A granted, portBStall=1 through A's EOP plus arbitration; next B packet then granted; both counts=1.
REQ-026 A sends SOP+EOP single-word packets back-to-back -> each forwarded with outSop=outEop=1, one IDLE gap, pktCntA counts each.
REQ-027 MAX_WORDS=8, A sends 10 words with no EOP -> 8th forwarded with outEop=1, errFrame pulse, words 9-10 dropped with errFrame, pktCntA=0.
REQ-028 B word with inSop=0 in IDLE -> dropped, errFrame pulse, no outValid.
REQ-029 reset asserted at word 3 of A packet -> outputs zero immediately, stalls high; after release, new B packet forwarded normally.
